// File: rtl/multdiv_ctrl.sv
// Sequencer between the execute stage and the shared multi-cycle multiply/divide unit:
// accepts mult/div in IDLE, starts the unit, stalls the pipe, then issues one writeback.
module multdiv_ctrl #(
  parameter int unsigned TIMEOUT    = 40,
  parameter logic [4:0]  MULT_OPC   = 5'b00110,
  parameter logic [4:0]  DIV_OPC    = 5'b00111,
  parameter logic [4:0]  STATUS_REG = 5'd30,
  parameter logic [31:0] MULT_EXC   = 32'd4,
  parameter logic [31:0] DIV_EXC    = 32'd5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  alu_opcode,
  input  logic [4:0]  issue_rd,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        flush,
  input  logic        md_ready,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        md_start_mult,
  output logic        md_start_div,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_WB} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] md_a_q, md_a_d;
  logic [31:0] md_b_q, md_b_d;
  logic        start_mult_q, start_mult_d;
  logic        start_div_q, start_div_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        accept;
  logic [31:0] exc_code;

  always_comb begin
    accept   = (state_q == S_IDLE) && issue_valid && !flush &&
               ((alu_opcode == MULT_OPC) || (alu_opcode == DIV_OPC));
    exc_code = is_div_q ? DIV_EXC : MULT_EXC;

    state_d      = state_q;
    cnt_d        = cnt_q;
    is_div_d     = is_div_q;
    rd_d         = rd_q;
    md_a_d       = md_a_q;
    md_b_d       = md_b_q;
    start_mult_d = 1'b0;
    start_div_d  = 1'b0;
    wb_valid_d   = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          md_a_d   = operand_a;
          md_b_d   = operand_b;
          rd_d     = issue_rd;
          is_div_d = (alu_opcode == DIV_OPC);
          state_d  = S_START;
        end
      end
      S_START: begin
        // The start pulse is registered on leaving START so a flush here suppresses it.
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          start_mult_d = !is_div_q;
          start_div_d  = is_div_q;
          cnt_d        = '0;
          state_d      = S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (md_ready) begin
          state_d = S_WB;
          if (md_exception) begin
            wb_rd_d    = STATUS_REG;
            wb_data_d  = exc_code;
            wb_valid_d = 1'b1;
          end else begin
            wb_rd_d    = rd_q;
            wb_data_d  = md_result;
            wb_valid_d = (rd_q != '0);
          end
        end else if (cnt_q == 6'(TIMEOUT - 1)) begin
          state_d    = S_WB;
          wb_rd_d    = STATUS_REG;
          wb_data_d  = exc_code;
          wb_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      is_div_q     <= 1'b0;
      rd_q         <= '0;
      md_a_q       <= '0;
      md_b_q       <= '0;
      start_mult_q <= 1'b0;
      start_div_q  <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_div_q     <= is_div_d;
      rd_q         <= rd_d;
      md_a_q       <= md_a_d;
      md_b_q       <= md_b_d;
      start_mult_q <= start_mult_d;
      start_div_q  <= start_div_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
    end
  end

  always_comb begin
    stall         = accept || (state_q == S_START) || (state_q == S_BUSY);
    busy          = (state_q != S_IDLE);
    md_start_mult = start_mult_q;
    md_start_div  = start_div_q;
    md_a          = md_a_q;
    md_b          = md_b_q;
    wb_valid      = wb_valid_q;
    wb_rd         = wb_rd_q;
    wb_data       = wb_data_q;
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Bench for multdiv_ctrl: a per-operation timeline model predicts every output for every
// cycle; a negedge process compares, and literal checks pin the model's key results.
module tb_multdiv_ctrl;
  localparam int TO   = 40;
  localparam int MAXC = 512;
  localparam logic [4:0] MULT_OPC = 5'b00110;
  localparam logic [4:0] DIV_OPC  = 5'b00111;

  logic        clock, reset, issue_valid, flush, md_ready, md_exception;
  logic [4:0]  alu_opcode, issue_rd;
  logic [31:0] operand_a, operand_b, md_result;
  logic        md_start_mult, md_start_div, stall, busy, wb_valid;
  logic [31:0] md_a, md_b, wb_data;
  logic [4:0]  wb_rd;

  multdiv_ctrl #(.TIMEOUT(TO)) u_dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .alu_opcode(alu_opcode),
    .issue_rd(issue_rd), .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .md_ready(md_ready), .md_exception(md_exception), .md_result(md_result),
    .md_start_mult(md_start_mult), .md_start_div(md_start_div), .md_a(md_a), .md_b(md_b),
    .stall(stall), .busy(busy), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic        exp_stall[MAXC], exp_busy[MAXC], exp_sm[MAXC], exp_sd[MAXC], exp_wbv[MAXC];
  logic [4:0]  exp_wbrd[MAXC];
  logic [31:0] exp_wbdata[MAXC], exp_mda[MAXC], exp_mdb[MAXC];

  int total = 0, passed = 0;
  int stall_cnt = 0, sm_cnt = 0, sd_cnt = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
  endtask

  always @(negedge clock) begin
    if (chk_en && cyc < MAXC) begin
      check("stall",         32'(stall),         32'(exp_stall[cyc]));
      check("busy",          32'(busy),          32'(exp_busy[cyc]));
      check("md_start_mult", 32'(md_start_mult), 32'(exp_sm[cyc]));
      check("md_start_div",  32'(md_start_div),  32'(exp_sd[cyc]));
      check("wb_valid",      32'(wb_valid),      32'(exp_wbv[cyc]));
      check("wb_rd",         32'(wb_rd),         32'(exp_wbrd[cyc]));
      check("wb_data",       wb_data,            exp_wbdata[cyc]);
      check("md_a",          md_a,               exp_mda[cyc]);
      check("md_b",          md_b,               exp_mdb[cyc]);
      if (stall === 1'b1) stall_cnt++;
      if (md_start_mult === 1'b1) sm_cnt++;
      if (md_start_div === 1'b1) sd_cnt++;
    end
  end

  initial begin
    #(MAXC * 10);
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic void span(int t, int stall_end, int busy_end);
    for (int c = t; c <= stall_end; c++) exp_stall[c] = 1'b1;
    for (int c = t + 1; c <= busy_end; c++) exp_busy[c] = 1'b1;
  endfunction

  function automatic void hold_ops(int from, logic [31:0] a, logic [31:0] b);
    for (int c = from; c < MAXC; c++) begin exp_mda[c] = a; exp_mdb[c] = b; end
  endfunction

  function automatic void hold_wb(int from, logic [4:0] rd, logic [31:0] d);
    for (int c = from; c < MAXC; c++) begin exp_wbrd[c] = rd; exp_wbdata[c] = d; end
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // k: BUSY cycle (1-based) carrying md_ready, 0 = never. flush_j: -1 in START, j>0 in BUSY
  // cycle j, 0 none. rst_j: reset in BUSY cycle j. Returns at the WB (or back-to-IDLE) cycle.
  task automatic run_op(input logic [4:0] opc, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input int k, input bit exc,
                        input logic [31:0] res, input int flush_j, input int rst_j);
    int t, nb, wbc, last, rdy_c, fl_c, rs_c, c;
    bit is_div, xc;
    t = cyc;
    rdy_c = -1; fl_c = -1; rs_c = -1;
    is_div = (opc == DIV_OPC);
    issue_valid = 1'b1; alu_opcode = opc; issue_rd = rd; operand_a = a; operand_b = b;
    flush = 1'b0; md_ready = 1'b0; md_exception = 1'b0;
    if (!(opc == MULT_OPC || opc == DIV_OPC)) begin
      next_cycle();
      issue_valid = 1'b0;
      return;
    end
    hold_ops(t + 1, a, b);
    if (flush_j != -1) begin
      if (is_div) exp_sd[t + 2] = 1'b1; else exp_sm[t + 2] = 1'b1;
    end
    if (rst_j > 0) begin
      rs_c = t + 1 + rst_j;
      span(t, rs_c, rs_c);
      hold_ops(rs_c + 1, '0, '0);
      hold_wb(rs_c + 1, '0, '0);
      last = rs_c + 1;
    end else if (flush_j == -1) begin
      fl_c = t + 1;
      span(t, t + 1, t + 1);
      last = t + 2;
    end else if (flush_j > 0 && (k == 0 || flush_j <= k)) begin
      fl_c = t + 1 + flush_j;
      if (k == flush_j) rdy_c = fl_c;
      span(t, fl_c, fl_c);
      last = fl_c + 1;
    end else begin
      nb  = (k == 0) ? TO : k;
      wbc = t + 2 + nb;
      if (k > 0) rdy_c = t + 1 + k;
      xc  = exc || (k == 0);
      span(t, t + 1 + nb, wbc);
      exp_wbv[wbc] = xc || (rd != 5'd0);
      hold_wb(wbc, xc ? 5'd30 : rd, xc ? (is_div ? 32'd5 : 32'd4) : res);
      last = wbc;
    end
    while (cyc < last) begin
      next_cycle();
      c = cyc;
      issue_valid  = (c < last);
      flush        = (c == fl_c);
      md_ready     = (c == rdy_c);
      md_exception = exc && (c == rdy_c);
      md_result    = (c == rdy_c) ? res : 32'hDEAD_BEEF;
      reset        = (c == rs_c);
    end
  endtask

  initial begin
    for (int c = 0; c < MAXC; c++) begin
      exp_stall[c] = 1'b0; exp_busy[c] = 1'b0; exp_sm[c] = 1'b0; exp_sd[c] = 1'b0;
      exp_wbv[c] = 1'b0; exp_wbrd[c] = '0; exp_wbdata[c] = '0; exp_mda[c] = '0; exp_mdb[c] = '0;
    end
    reset = 1'b1; issue_valid = 1'b0; alu_opcode = '0; issue_rd = '0;
    operand_a = '0; operand_b = '0; flush = 1'b0; md_ready = 1'b0;
    md_exception = 1'b0; md_result = '0;
    next_cycle();
    chk_en = 1'b1;
    next_cycle();
    reset = 1'b0;
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_md_a", md_a, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    next_cycle();

    // basic mult, result on the 2nd BUSY cycle
    stall_cnt = 0; sm_cnt = 0; sd_cnt = 0;
    run_op(MULT_OPC, 5'd5, 32'd7, 32'd6, 2, 1'b0, 32'd42, 0, 0);
    check("mult_wb_valid", 32'(wb_valid), 32'd1);
    check("mult_wb_rd", 32'(wb_rd), 32'd5);
    check("mult_wb_data", wb_data, 32'd42);
    next_cycle();
    check("mult_stall_cycles", 32'(stall_cnt), 32'd4);
    check("mult_start_pulses", 32'(sm_cnt), 32'd1);
    check("mult_md_a", md_a, 32'd7);

    // divide by zero, unit reports exception
    sd_cnt = 0;
    run_op(DIV_OPC, 5'd9, 32'd100, 32'd0, 1, 1'b1, 32'h1234, 0, 0);
    check("div_exc_rd", 32'(wb_rd), 32'd30);
    check("div_exc_data", wb_data, 32'd5);
    next_cycle();
    check("div_start_pulses", 32'(sd_cnt), 32'd1);

    // timeout: md_ready never comes
    stall_cnt = 0;
    run_op(MULT_OPC, 5'd3, 32'd1, 32'd2, 0, 1'b0, 32'd0, 0, 0);
    check("to_rd", 32'(wb_rd), 32'd30);
    check("to_data", wb_data, 32'd4);
    next_cycle();
    check("to_stall_cycles", 32'(stall_cnt), 32'(TO + 2));
    check("to_idle", 32'(busy), 32'd0);

    // flush and md_ready together in BUSY: flush wins
    run_op(MULT_OPC, 5'd6, 32'd11, 32'd9, 3, 1'b0, 32'd99, 3, 0);
    check("flush_wb_valid", 32'(wb_valid), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_stall", 32'(stall), 32'd0);
    check("flush_wb_data_held", wb_data, 32'd4);
    next_cycle();

    // flush in START suppresses the start pulse
    sd_cnt = 0;
    run_op(DIV_OPC, 5'd12, 32'd8, 32'd2, 2, 1'b0, 32'd4, -1, 0);
    next_cycle();
    check("startflush_pulses", 32'(sd_cnt), 32'd0);

    // non-multdiv op, stray unit pulse in IDLE, flush in the accept cycle
    stall_cnt = 0;
    run_op(5'b00000, 5'd4, 32'd1, 32'd1, 1, 1'b0, 32'd0, 0, 0);
    md_ready = 1'b1; md_exception = 1'b1; md_result = 32'h5555;
    next_cycle();
    md_ready = 1'b0; md_exception = 1'b0;
    issue_valid = 1'b1; alu_opcode = MULT_OPC; flush = 1'b1;
    next_cycle();
    issue_valid = 1'b0; flush = 1'b0;
    next_cycle();
    check("nonmd_stall_cycles", 32'(stall_cnt), 32'd0);

    // mult to r0: no writeback strobe
    run_op(MULT_OPC, 5'd0, 32'd3, 32'd4, 1, 1'b0, 32'd12, 0, 0);
    check("r0_wb_valid", 32'(wb_valid), 32'd0);
    next_cycle();

    // back-to-back: second op presented the cycle after WB
    run_op(MULT_OPC, 5'd7, 32'd2, 32'd3, 1, 1'b0, 32'd6, 0, 0);
    next_cycle();
    run_op(DIV_OPC, 5'd8, 32'd154, 32'd2, 1, 1'b0, 32'd77, 0, 0);
    check("b2b_wb_rd", 32'(wb_rd), 32'd8);
    check("b2b_wb_data", wb_data, 32'd77);
    next_cycle();

    // reset in BUSY
    run_op(MULT_OPC, 5'd10, 32'hAAAA, 32'h5555, 5, 1'b0, 32'd1, 0, 3);
    check("rstbusy_busy", 32'(busy), 32'd0);
    check("rstbusy_md_a", md_a, 32'd0);
    check("rstbusy_wb_data", wb_data, 32'd0);
    next_cycle();

    run_op(MULT_OPC, 5'd11, 32'd5, 32'd1, 1, 1'b0, 32'd5, 0, 0);
    check("recover_wb_data", wb_data, 32'd5);
    repeat (3) next_cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Sequencer between the execute stage and the shared multi-cycle multiply/divide unit.
- In IDLE it accepts a decoded ALU-class instruction whose ALU opcode is mult or div.
- It latches the operands and destination, pulses the unit's start control, and stalls the pipeline until the unit answers or times out.
- It then issues a one-cycle register writeback: the result to rd, or an exception code to the status register.

Parameters:
- TIMEOUT, 40: maximum BUSY cycles before forced exception; legal range 2..63.
- MULT_OPC, 5'b00110: ALU opcode for mult.
- DIV_OPC, 5'b00111: ALU opcode for div.
- STATUS_REG, 30: register written on exception.
- MULT_EXC, 4: status value for mult overflow or timeout.
- DIV_EXC, 5: status value for divide-by-zero or timeout.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  execute stage holds a valid ALU-class instruction.
- alu_opcode  in  5  ALU opcode field of that instruction.
- issue_rd  in  5  destination register.
- operand_a  in  32  rs value.
- operand_b  in  32  rt value.
- flush  in  1  squash in-flight operation (branch or jump taken).
- md_ready  in  1  unit result valid (one-cycle pulse).
- md_exception  in  1  unit exception, qualified by md_ready.
- md_result  in  32  unit result, qualified by md_ready.
- md_start_mult  out  1  one-cycle start pulse, mult.
- md_start_div  out  1  one-cycle start pulse, div.
- md_a  out  32  latched operand A.
- md_b  out  32  latched operand B.
- stall  out  1  freeze PC, F/D and D/X.
- busy  out  1  state is not IDLE.
- wb_valid  out  1  writeback strobe.
- wb_rd  out  5  writeback register.
- wb_data  out  32  writeback data.

Behaviour:
- **Reset.**
  - State goes to IDLE.
  - All registered outputs clear to 0: md_a, md_b, wb_rd, wb_data, start pulses, wb_valid.
  - Cycle counter clears to 0.
- **Accept condition.** accept = IDLE & issue_valid & (alu_opcode==MULT_OPC | alu_opcode==DIV_OPC) & !flush.
  - On accept, latch operand_a, operand_b, issue_rd and an is_div flag, then go to START.
  - Accept is evaluated only in IDLE, so an instruction still held in X is never re-accepted.
- **stall** is combinational: accept | START | BUSY. It is 0 in IDLE without accept, and 0 in WB.
- **START (1 cycle).**
  - Assert md_start_div if is_div, else md_start_mult.
  - Clear the counter and go to BUSY.
  - If flush: no start pulse, go to IDLE.
- **BUSY.** Evaluate in this priority order:
  - flush → IDLE, no writeback. Flush wins even if md_ready is high in the same cycle.
  - md_ready → go to WB.
    - No exception: wb_rd=latched rd, wb_data=md_result.
    - Exception: wb_rd=STATUS_REG, wb_data=DIV_EXC if is_div, else MULT_EXC.
  - counter==TIMEOUT-1 → go to WB with the exception writeback above.
  - Otherwise increment the counter.
- **WB (1 cycle).**
  - wb_valid=1, except 0 when the normal (non-exception) destination is r0.
  - Go to IDLE. A new accept is possible on the following cycle.
- **Latency.** Total latency from accept to wb_valid = 3 + (cycles spent in BUSY before md_ready).
  - With md_ready on the first BUSY cycle: wb_valid appears 3 cycles after the accept edge.
- **Unit inputs outside BUSY.** md_ready is ignored in IDLE, START and WB; stray pulses are dropped.
- **Outputs outside WB.** wb_valid=0; wb_rd and wb_data hold their last value.
- **Reset mid-operation.** Reset overrides everything: IDLE, no writeback, no start pulse.

Test Plan:
- **Basic mult.**
  - Stimulus: reset, then issue_valid with op 00110, rd=5, a=7, b=6; md_ready with result 42 on the 2nd BUSY cycle.
  - Required: one md_start_mult pulse; stall high for exactly 4 cycles (accept, START, 2 BUSY); wb_valid 1 cycle with wb_rd=5, wb_data=42.
- **Divide exception.**
  - Stimulus: div with b=0; md_ready and md_exception together.
  - Required: md_start_div pulses; wb_rd=30, wb_data=5.
- **Timeout.**
  - Stimulus: mult issued, md_ready never asserted.
  - Required: after exactly TIMEOUT BUSY cycles, wb_rd=30, wb_data=4; returns to IDLE.
- **Flush.**
  - Stimulus: flush and md_ready asserted in the same BUSY cycle.
  - Required: no wb_valid; IDLE next cycle; stall low.
- **Non-multdiv and r0.**
  - Stimulus: issue_valid with op 00000 (add).
  - Required: no stall, no start pulse.
  - Stimulus: mult with rd=0 and a normal result.
  - Required: wb_valid stays 0.
- **Back-to-back and reset.**
  - Stimulus: second mult presented the cycle after WB.
  - Required: accepted immediately.
  - Stimulus: reset asserted in BUSY.
  - Required: IDLE, all outputs 0 next cycle.
